// File: rtl/writeback_queue_pkg.sv
// rtl/writeback_queue_pkg.sv - shared opcode/funct3 constants for the writeback stage
package writeback_queue_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYS    = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_OP) ||
           (opc == OPC_OPIMM) || (opc == OPC_JAL) || (opc == OPC_JALR) ||
           (opc == OPC_LOAD);
  endfunction

endpackage

// File: rtl/writeback_queue_load_align.sv
// rtl/writeback_queue_load_align.sv - byte/halfword extraction and extension of load data
module wb_load_align
  import writeback_queue_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (off_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // halfword select ignores off_i[0]; misaligned halves are not split
    half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - result select, register-write FIFO, forwarding search, instret
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int DEPTH = 2,
  parameter int CNT_W = 64
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [4:0]       in_rd,
  input  logic [XLEN-1:0]  in_data,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  input  logic             rf_ready,
  input  logic [4:0]       chk_rs1,
  input  logic [4:0]       chk_rs2,
  output logic             fwd1_hit,
  output logic [XLEN-1:0]  fwd1_data,
  output logic             fwd2_hit,
  output logic [XLEN-1:0]  fwd2_data,
  output logic [CNT_W-1:0] instret
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CQ_W  = $clog2(DEPTH + 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_inst;

  assign opcode      = in_inst[6:0];
  assign funct3      = in_inst[14:12];
  assign unused_inst = ^{in_inst[31:15], in_inst[11:7]};

  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] res_data;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i (funct3),
    .off_i    (in_alu[1:0]),
    .word_i   (in_data),
    .data_o   (load_data)
  );

  always_comb begin
    res_data = in_alu;
    case (opcode)
      OPC_JAL, OPC_JALR: res_data = in_pc + XLEN'(4);
      OPC_LOAD:          res_data = load_data;
      default:           res_data = in_alu;
    endcase
  end

  logic [4:0]       rd_mem_q   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CQ_W-1:0]  count_q, count_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic accept, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No fall-through: a pop in the same cycle does not free a slot for a full queue
  assign in_ready = (count_q < CQ_W'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = accept & writes_rd(opcode) & (in_rd != 5'd0);
  assign pop      = we_q & rf_ready;

  always_comb begin
    head_d    = pop  ? ptr_inc(head_q) : head_q;
    tail_d    = push ? ptr_inc(tail_q) : tail_q;
    count_d   = count_q;
    if (push && !pop)
      count_d = count_q + 1'b1;
    else if (!push && pop)
      count_d = count_q - 1'b1;
    instret_d = accept ? instret_q + CNT_W'(1) : instret_q;
    we_d      = (count_d != '0);
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    // Next head is the incoming entry when nothing older survives this cycle
    if (count_d != '0) begin
      if ((count_q == '0) || ((count_q == CQ_W'(1)) && pop)) begin
        waddr_d = in_rd;
        wdata_d = res_data;
      end else begin
        waddr_d = rd_mem_q[head_d];
        wdata_d = data_mem_q[head_d];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      instret_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      instret_q <= instret_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      rd_mem_q[tail_q]   <= in_rd;
      data_mem_q[tail_q] <= res_data;
    end
  end

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    int idx;
    idx       = 0;
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = int'(head_q) + i;
      if (idx >= DEPTH)
        idx = idx - DEPTH;
      if (i < int'(count_q)) begin
        if ((chk_rs1 != 5'd0) && (rd_mem_q[idx[PTR_W-1:0]] == chk_rs1)) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_mem_q[idx[PTR_W-1:0]];
        end
        if ((chk_rs2 != 5'd0) && (rd_mem_q[idx[PTR_W-1:0]] == chk_rs2)) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_mem_q[idx[PTR_W-1:0]];
        end
      end
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue
module tb_writeback_queue;
  import writeback_queue_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 5;

  logic             CLK = 1'b0;
  logic             RES;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_alu;
  logic [4:0]       in_rd;
  logic [XLEN-1:0]  in_data;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;
  logic             rf_ready;
  logic [4:0]       chk_rs1;
  logic [4:0]       chk_rs2;
  logic             fwd1_hit;
  logic [XLEN-1:0]  fwd1_data;
  logic             fwd2_hit;
  logic [XLEN-1:0]  fwd2_data;
  logic [CNT_W-1:0] instret;

  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] exp_ir;

  writeback_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RES(RES),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .in_alu(in_alu), .in_rd(in_rd), .in_data(in_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .instret(instret)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one entry for a single cycle; caller knows it will be accepted
  task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [31:0] data);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    in_alu   = alu;
    in_rd    = rd;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    exp_ir   = exp_ir + 1'b1;
  endtask

  initial begin
    RES = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; in_alu = '0; in_rd = '0;
    in_data = '0; rf_ready = 1'b1; chk_rs1 = '0; chk_rs2 = '0; exp_ir = '0;
    repeat (2) @(posedge CLK);
    #1;
    RES = 1'b0;
    chk("rst_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_instret", instret, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_fwd1", fwd1_hit, 0);

    issue(32'h100, mk(OPC_LUI, 3'd0), 32'h12345000, 5'd5, 32'h0);
    chk("lui_we", rf_we, 1);
    chk("lui_waddr", rf_waddr, 5);
    chk("lui_wdata", rf_wdata, 32'h12345000);
    chk("lui_instret", instret, 1);
    tick();
    chk("empty_we", rf_we, 0);
    chk("empty_hold_waddr", rf_waddr, 5);
    chk("empty_hold_wdata", rf_wdata, 32'h12345000);

    issue(32'h104, mk(OPC_LOAD, F3_LB), 32'h3, 5'd6, 32'h80FFFFFF);
    chk("lb", rf_wdata, 32'hFFFFFF80);
    issue(32'h108, mk(OPC_LOAD, F3_LBU), 32'h3, 5'd6, 32'h80FFFFFF);
    chk("lbu", rf_wdata, 32'h00000080);
    issue(32'h10C, mk(OPC_LOAD, F3_LHU), 32'h2, 5'd6, 32'hBEEF0000);
    chk("lhu", rf_wdata, 32'h0000BEEF);
    issue(32'h110, mk(OPC_LOAD, F3_LH), 32'h3, 5'd6, 32'h80010000);
    chk("lh_off3", rf_wdata, 32'hFFFF8001);
    issue(32'h114, mk(OPC_LOAD, F3_LW), 32'h1, 5'd6, 32'hCAFEBABE);
    chk("lw", rf_wdata, 32'hCAFEBABE);
    issue(32'h118, mk(OPC_LOAD, 3'b111), 32'h2, 5'd6, 32'h87654321);
    chk("load_bad_f3", rf_wdata, 32'h87654321);
    issue(32'h11C, mk(OPC_OP, 3'd0), 32'hA5A5A5A5, 5'd9, 32'h0);
    chk("op_waddr", rf_waddr, 9);
    chk("op_wdata", rf_wdata, 32'hA5A5A5A5);
    issue(32'hFFFFFFFC, mk(OPC_JAL, 3'd0), 32'h0, 5'd1, 32'h0);
    chk("jal_waddr", rf_waddr, 1);
    chk("jal_wdata", rf_wdata, 32'h0);
    issue(32'h200, mk(OPC_STORE, 3'd2), 32'h40, 5'd3, 32'h0);
    chk("store_we", rf_we, 0);
    chk("store_hold", rf_waddr, 1);
    issue(32'h204, mk(OPC_OPIMM, 3'd0), 32'h55, 5'd0, 32'h0);
    chk("rd0_we", rf_we, 0);
    chk("rd0_instret", instret, exp_ir);

    rf_ready = 1'b0;
    issue(32'h300, mk(OPC_OPIMM, 3'd0), 32'h11, 5'd7, 32'h0);
    chk("stall1_we", rf_we, 1);
    chk("stall1_ready", in_ready, 1);
    issue(32'h304, mk(OPC_OPIMM, 3'd0), 32'h22, 5'd7, 32'h0);
    chk("full_ready", in_ready, 0);
    chk("full_waddr", rf_waddr, 7);
    chk("full_wdata", rf_wdata, 32'h11);
    chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    #1;
    chk("fwd1_hit", fwd1_hit, 1);
    chk("fwd1_young", fwd1_data, 32'h22);
    chk("fwd2_zero", fwd2_hit, 0);
    chk_rs2 = 5'd5;
    #1;
    chk("fwd2_miss", fwd2_hit, 0);
    chk("fwd2_miss_data", fwd2_data, 0);
    in_valid = 1'b1; in_inst = mk(OPC_OPIMM, 3'd0); in_alu = 32'h33; in_rd = 5'd8;
    tick();
    in_valid = 1'b0;
    chk("full_no_accept", instret, exp_ir);
    chk("stall_stable", rf_wdata, 32'h11);
    rf_ready = 1'b1;
    #1;
    chk("full_pop_ready", in_ready, 0);
    chk("pop_fwd_hit", fwd1_hit, 1);
    tick();
    chk("pop1_wdata", rf_wdata, 32'h22);
    chk("pop1_ready", in_ready, 1);
    tick();
    chk("pop2_we", rf_we, 0);

    rf_ready = 1'b0;
    issue(32'h400, mk(OPC_OP, 3'd0), 32'h1, 5'd10, 32'h0);
    issue(32'h404, mk(OPC_OP, 3'd0), 32'h2, 5'd11, 32'h0);
    RES = 1'b1;
    tick();
    RES = 1'b0;
    exp_ir = '0;
    chk("res_we", rf_we, 0);
    chk("res_ready", in_ready, 1);
    chk("res_instret", instret, 0);
    chk("res_waddr", rf_waddr, 0);
    chk_rs1 = 5'd10;
    #1;
    chk("res_fwd", fwd1_hit, 0);

    rf_ready = 1'b1;
    for (int k = 0; k < 31; k++)
      issue(32'h500, mk(OPC_OPIMM, 3'd0), 32'h0, 5'd0, 32'h0);
    chk("ir_allones", instret, 5'h1F);
    issue(32'h504, mk(OPC_OPIMM, 3'd0), 32'h0, 5'd0, 32'h0);
    chk("ir_wrap", instret, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
